sar_adc_sequencer: RTL and testbench

SAR_ADC_SEQUENCER -- requirements
Module: sar_adc_sequencer

---
 rtl/sar_adc_sequencer.sv | 144 ++++++++++++++
 tb/tb_sar_adc_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_sequencer.sv
// ============================================================================
// Module : sar_adc_sequencer
// Track/hold and binary-search sequencer for a capacitive-DAC SAR converter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sar_adc_sequencer #(
    parameter int CADC_WIDTH   = 10,
    parameter int SAMPLE_TICKS = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLK_ADC,
    input  logic                  RSTN_ADC,
    input  logic                  CLRN,
    input  logic                  COMP_IN,
    output logic                  SAMPLE,
    output logic [CADC_WIDTH-1:0] DAC_CODE,
    output logic [CADC_WIDTH-1:0] ADC,
    output logic                  ADC_RDY
);

    localparam int IDXW = (CADC_WIDTH > 1) ? $clog2(CADC_WIDTH) : 1;

    localparam logic [IDXW-1:0]       C_IDX_MSB  = IDXW'(CADC_WIDTH - 1);
    localparam logic [3:0]            C_CNT_LAST = 4'(SAMPLE_TICKS - 1);
    localparam logic [CADC_WIDTH-1:0] C_DAC_MSB  = {1'b1, {(CADC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRACK   = 2'd1,
        S_CONVERT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_clk_adc_q;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [IDXW-1:0]       r_idx;
    logic [IDXW-1:0]       w_idx_nxt;
    logic [CADC_WIDTH-1:0] r_dac;
    logic [CADC_WIDTH-1:0] w_dac_nxt;
    logic [CADC_WIDTH-1:0] r_adc;
    logic [CADC_WIDTH-1:0] w_adc_nxt;
    logic                  r_rdy;
    logic                  w_rdy_nxt;
    logic                  w_tick;

    // One-cycle strobe per CLK_ADC rising edge, independent of its high time
    assign w_tick = CLK_ADC & ~r_clk_adc_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_clk_adc_q <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= C_IDX_MSB;
            r_dac       <= '0;
            r_adc       <= '0;
            r_rdy       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_adc_q <= CLK_ADC;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_dac       <= w_dac_nxt;
            r_adc       <= w_adc_nxt;
            r_rdy       <= w_rdy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dac_nxt   = r_dac;
        w_adc_nxt   = r_adc;
        w_rdy_nxt   = r_rdy;

        if (!RSTN_ADC) begin
            // Abort discards the partial code but keeps the last result
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = C_IDX_MSB;
            w_dac_nxt   = '0;
            w_rdy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_TRACK;
                    w_cnt_nxt   = '0;
                    w_dac_nxt   = '0;
                end
                S_TRACK: begin
                    if (w_tick) begin
                        if (r_cnt == C_CNT_LAST) begin
                            w_state_nxt = S_CONVERT;
                            w_cnt_nxt   = '0;
                            w_dac_nxt   = C_DAC_MSB;
                            w_idx_nxt   = C_IDX_MSB;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end
                end
                S_CONVERT: begin
                    if (w_tick) begin
                        w_dac_nxt[r_idx] = COMP_IN;
                        if (r_idx == '0) begin
                            w_adc_nxt   = {r_dac[CADC_WIDTH-1:1], COMP_IN};
                            w_rdy_nxt   = 1'b1;
                            w_state_nxt = S_TRACK;
                            w_cnt_nxt   = '0;
                            w_dac_nxt   = '0;
                            w_idx_nxt   = C_IDX_MSB;
                        end else begin
                            w_dac_nxt[r_idx - 1'b1] = 1'b1;
                            w_idx_nxt               = r_idx - 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Clear takes priority over a result landing in the same cycle
        if (!CLRN) begin
            w_adc_nxt = '0;
            w_rdy_nxt = 1'b0;
        end
    end

    assign SAMPLE   = (r_state == S_TRACK);
    assign DAC_CODE = r_dac;
    assign ADC      = r_adc;
    assign ADC_RDY  = r_rdy;

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_sequencer.sv
// ============================================================================
// Module : tb_sar_adc_sequencer
// Scoreboard bench for sar_adc_sequencer with a threshold comparator model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sar_adc_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       CLK_ADC;
    logic       RSTN_ADC;
    logic       CLRN;
    logic       COMP_IN;
    logic       SAMPLE;
    logic [9:0] DAC_CODE;
    logic [9:0] ADC;
    logic       ADC_RDY;

    logic       comp_force_en;
    logic       comp_force_val;
    logic [9:0] thr;

    int         n_vec;
    int         n_err;
    int         done_cnt;
    int         exp_done;
    logic [10:0] sb[$];

    logic [9:0] seq [10] = '{10'd512, 10'd256, 10'd384, 10'd448, 10'd480,
                             10'd496, 10'd504, 10'd508, 10'd506, 10'd507};

    sar_adc_sequencer #(
        .CADC_WIDTH   (10),
        .SAMPLE_TICKS (2)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CLK_ADC  (CLK_ADC),
        .RSTN_ADC (RSTN_ADC),
        .CLRN     (CLRN),
        .COMP_IN  (COMP_IN),
        .SAMPLE   (SAMPLE),
        .DAC_CODE (DAC_CODE),
        .ADC      (ADC),
        .ADC_RDY  (ADC_RDY)
    );

    // Comparator: Vin >= DAC(code) modelled as code <= threshold
    assign COMP_IN = comp_force_en ? comp_force_val : (DAC_CODE <= thr);

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_result(input logic rdy, input logic [9:0] adc);
        sb.push_back({rdy, adc});
        exp_done++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (done_cnt >= exp_done) return;
            @(negedge CLK);
        end
        n_vec++;
        n_err++;
        $display("FAIL conv_timeout: got %0d results, expected %0d", done_cnt, exp_done);
        exp_done = done_cnt;
    endtask

    // One CLK_ADC pulse: hi cycles high then lo cycles low; CLRN/RSTN_ADC set in the rising cycle
    task automatic adc_tick(input int hi, input int lo, input logic clrn_v, input logic rstn_v);
        @(posedge CLK); #1;
        CLK_ADC  = 1'b1;
        CLRN     = clrn_v;
        RSTN_ADC = rstn_v;
        @(posedge CLK); #1;
        CLRN = 1'b1;
        repeat (hi - 1) begin @(posedge CLK); #1; end
        CLK_ADC = 1'b0;
        repeat (lo - 1) begin @(posedge CLK); #1; end
    endtask

    task automatic full_conv(input int hi, input int lo, input logic fclrn,
                             input logic frstn, input bit chk);
        for (int k = 0; k < 12; k++) begin
            if (k == 11) adc_tick(hi, lo, fclrn, frstn);
            else         adc_tick(hi, lo, 1'b1, 1'b1);
            if (chk) begin
                @(negedge CLK);
                if (k >= 1 && k <= 10) check($sformatf("dac_seq[%0d]", k - 1), 32'(DAC_CODE), 32'(seq[k-1]));
                if (k == 10) check("rdy_before_final_tick", 32'(ADC_RDY), 32'd0);
            end
        end
    endtask

    // Monitor: a result is presented when TRACK is re-entered from a conversion
    initial begin
        logic       m_prev_adc;
        logic       m_prev_sample;
        logic [9:0] m_prev_dac;
        int         m_ticks;
        logic [10:0] e;
        m_prev_adc = 1'b0; m_prev_sample = 1'b0; m_prev_dac = '0; m_ticks = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                m_prev_adc = 1'b0; m_prev_sample = 1'b0; m_prev_dac = '0; m_ticks = 0;
            end else begin
                if (SAMPLE && !m_prev_sample) begin
                    if (m_prev_dac != '0) begin
                        if (sb.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_result: got ADC=%0d, expected no conversion", ADC);
                        end else begin
                            e = sb.pop_front();
                            check("adc_result", 32'(ADC), 32'(e[9:0]));
                            check("adc_rdy", 32'(ADC_RDY), 32'(e[10]));
                            check("conv_ticks", 32'(m_ticks), 32'd12);
                        end
                        done_cnt++;
                    end
                    m_ticks = 0;
                end
                if (CLK_ADC && !m_prev_adc) m_ticks++;
                m_prev_adc    = CLK_ADC;
                m_prev_sample = SAMPLE;
                m_prev_dac    = DAC_CODE;
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; done_cnt = 0; exp_done = 0;
        RST_N = 1'b0; RSTN_ADC = 1'b1; CLRN = 1'b1; CLK_ADC = 1'b0;
        comp_force_en = 1'b0; comp_force_val = 1'b0; thr = 10'd507;

        repeat (3) @(negedge CLK);
        check("reset_sample", 32'(SAMPLE), 32'd0);
        check("reset_dac", 32'(DAC_CODE), 32'd0);
        check("reset_adc", 32'(ADC), 32'd0);
        check("reset_rdy", 32'(ADC_RDY), 32'd0);

        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle_before_first_edge", 32'(SAMPLE), 32'd0);
        @(negedge CLK);
        check("track_on_first_edge", 32'(SAMPLE), 32'd1);

        // Binary search toward 507 with CLK_ADC = CLK/8
        expect_result(1'b1, 10'd507);
        full_conv(4, 4, 1'b1, 1'b1, 1'b1);
        wait_done();

        comp_force_en = 1'b1; comp_force_val = 1'b0;
        for (int r = 0; r < 2; r++) begin
            expect_result(1'b1, 10'd0);
            full_conv(1, 1, 1'b1, 1'b1, 1'b0);
            wait_done();
        end
        comp_force_val = 1'b1;
        for (int r = 0; r < 2; r++) begin
            expect_result(1'b1, 10'd1023);
            full_conv(1, 1, 1'b1, 1'b1, 1'b0);
            wait_done();
        end

        // Abort after 2 track ticks and 5 convert ticks
        comp_force_en = 1'b0; thr = 10'd300;
        for (int k = 0; k < 7; k++) adc_tick(1, 1, 1'b1, 1'b1);
        @(negedge CLK);
        check("partial_dac", 32'(DAC_CODE), 32'd304);
        @(posedge CLK); #1;
        RSTN_ADC = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("abort_sample", 32'(SAMPLE), 32'd0);
        check("abort_dac", 32'(DAC_CODE), 32'd0);
        check("abort_rdy", 32'(ADC_RDY), 32'd0);
        check("abort_adc_kept", 32'(ADC), 32'd1023);
        repeat (3) @(negedge CLK);
        check("idle_held", 32'(SAMPLE), 32'd0);

        @(posedge CLK); #1;
        RSTN_ADC = 1'b1;
        expect_result(1'b1, 10'd300);
        full_conv(1, 1, 1'b1, 1'b1, 1'b0);
        wait_done();

        // Clear coinciding with the final tick wins; the next conversion is normal
        thr = 10'd700;
        expect_result(1'b0, 10'd0);
        full_conv(1, 1, 1'b0, 1'b1, 1'b0);
        wait_done();
        expect_result(1'b1, 10'd700);
        full_conv(1, 1, 1'b1, 1'b1, 1'b0);
        wait_done();

        // Abort coinciding with the final tick wins
        thr = 10'd100;
        full_conv(1, 1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("final_abort_adc_kept", 32'(ADC), 32'd700);
        check("final_abort_rdy", 32'(ADC_RDY), 32'd0);
        check("final_abort_sample", 32'(SAMPLE), 32'd0);
        check("final_abort_dac", 32'(DAC_CODE), 32'd0);

        // A long CLK_ADC high period is a single tick
        @(posedge CLK); #1;
        RSTN_ADC = 1'b1;
        adc_tick(20, 2, 1'b1, 1'b1);
        @(negedge CLK);
        check("hold_high_one_tick", 32'(SAMPLE), 32'd1);
        adc_tick(1, 1, 1'b1, 1'b1);
        @(negedge CLK);
        check("second_tick_converts", 32'(SAMPLE), 32'd0);
        check("second_tick_dac", 32'(DAC_CODE), 32'd512);

        // Asynchronous reset in the middle of TRACK
        @(posedge CLK); #1;
        RSTN_ADC = 1'b0;
        @(posedge CLK); #1;
        RSTN_ADC = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("retrack_sample", 32'(SAMPLE), 32'd1);
        adc_tick(1, 1, 1'b1, 1'b1);
        @(posedge CLK); #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_sample", 32'(SAMPLE), 32'd0);
        check("async_rst_dac", 32'(DAC_CODE), 32'd0);
        check("async_rst_adc", 32'(ADC), 32'd0);
        check("async_rst_rdy", 32'(ADC_RDY), 32'd0);

        repeat (2) @(negedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
